// File: rtl/fork_seq_pkg.sv
// Shared types and helpers for the fork/join load sequencer.
package fork_seq_pkg;

    // Widest supported channel count and the index width that covers it.
    localparam int unsigned MaxCh = 16;
    localparam int unsigned IdxW  = 4;

    typedef enum logic [2:0] {
        StIdle,
        StWaitBase,
        StLoadPar,
        StSeqGap,
        StSeqLoad,
        StFinish
    } state_e;

    typedef struct packed {
        logic            found;
        logic [IdxW-1:0] idx;
    } pick_t;

    // Index of the lowest set bit in mask, with a flag when any bit is set.
    function automatic pick_t lowest_set(input logic [MaxCh-1:0] mask);
        pick_t res;
        res = '0;
        for (int i = MaxCh - 1; i >= 0; i--) begin
            if (mask[i]) begin
                res.found = 1'b1;
                res.idx   = IdxW'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_pick.sv
// Combinational next-channel selection: lowest remaining sequential channel.
module seq_pick
    import fork_seq_pkg::*;
#(
    parameter int unsigned NCH = 6
) (
    input  logic [NCH-1:0] rem_i,
    output logic           found_o,
    output logic [NCH-1:0] onehot_o
);

    pick_t pick;

    // Decode the lowest remaining channel into a one-hot load select.
    always_comb begin
        pick     = lowest_set(MaxCh'(rem_i));
        found_o  = pick.found;
        onehot_o = '0;
        for (int i = 0; i < NCH; i++) begin
            onehot_o[i] = pick.found && (pick.idx == IdxW'(i));
        end
    end

endmodule

// File: rtl/fork_load_sequencer.sv
// Loads one captured value into NCH channels: a parallel (fork) group after a
// base delay, then the remaining channels one at a time, then a join pulse.
module fork_load_sequencer
    import fork_seq_pkg::*;
#(
    parameter int unsigned NCH   = 6,
    parameter int unsigned WIDTH = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [WIDTH-1:0]     value_i,
    input  logic [NCH-1:0]       par_mask_i,
    input  logic [CNT_W-1:0]     base_dly_i,
    input  logic [CNT_W-1:0]     step_dly_i,
    output logic [NCH*WIDTH-1:0] ch_data_o,
    output logic [NCH-1:0]       ch_valid_o,
    output logic                 busy_o,
    output logic                 done_o
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NCH-1:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     value_q;
    logic [NCH-1:0]       par_q;
    logic [CNT_W-1:0]     base_q;
    logic [CNT_W-1:0]     step_q;
    logic [NCH*WIDTH-1:0] ch_data_q;
    logic [NCH-1:0]       ch_valid_q;
    logic                 done_q, done_d;
    logic                 accept;
    logic [NCH-1:0]       load_mask;
    logic                 pick_found;
    logic [NCH-1:0]       pick_onehot;

    seq_pick #(
        .NCH (NCH)
    ) u_seq_pick (
        .rem_i    (rem_q),
        .found_o  (pick_found),
        .onehot_o (pick_onehot)
    );

    // Next-state, delay counting and per-edge load selection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        accept    = 1'b0;
        load_mask = '0;

        unique case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    accept  = 1'b1;
                    rem_d   = ~par_mask_i;
                    cnt_d   = CNT_W'(1);
                    state_d = (base_dly_i == '0) ? StLoadPar : StWaitBase;
                end
            end
            StWaitBase: begin
                if (cnt_q == base_q) state_d = StLoadPar;
                else                 cnt_d   = cnt_q + CNT_W'(1);
            end
            StLoadPar, StSeqLoad: begin
                // The parallel edge also carries the first sequential channel.
                load_mask = pick_onehot;
                if (state_q == StLoadPar) load_mask = load_mask | par_q;
                rem_d = rem_q & ~pick_onehot;
                if (!pick_found || rem_d == '0) begin
                    state_d = StFinish;
                end else if (step_q == '0) begin
                    state_d = StSeqLoad;
                end else begin
                    state_d = StSeqGap;
                    cnt_d   = CNT_W'(1);
                end
            end
            StSeqGap: begin
                if (cnt_q == step_q) state_d = StSeqLoad;
                else                 cnt_d   = cnt_q + CNT_W'(1);
            end
            StFinish: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // Abort cancels the edge's load and any pending join.
        if (abort_i && state_q != StIdle) begin
            state_d   = StIdle;
            load_mask = '0;
            done_d    = 1'b0;
        end
    end

    // State, captured run parameters and channel registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rem_q      <= '0;
            value_q    <= '0;
            par_q      <= '0;
            base_q     <= '0;
            step_q     <= '0;
            ch_data_q  <= '0;
            ch_valid_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            if (accept) begin
                value_q    <= value_i;
                par_q      <= par_mask_i;
                base_q     <= base_dly_i;
                step_q     <= step_dly_i;
                ch_valid_q <= '0;
            end else begin
                ch_valid_q <= ch_valid_q | load_mask;
            end
            for (int i = 0; i < NCH; i++) begin
                if (load_mask[i]) ch_data_q[i*WIDTH +: WIDTH] <= value_q;
            end
        end
    end

    assign ch_data_o  = ch_data_q;
    assign ch_valid_o = ch_valid_q;
    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;

endmodule

// File: tb/tb_fork_load_sequencer.sv
// Directed bench for fork_load_sequencer; edge numbers count from the start
// acceptance edge (edge 0) and outputs are sampled 1 time unit after each edge.
module tb_fork_load_sequencer;

    localparam int unsigned NCH   = 6;
    localparam int unsigned WIDTH = 2;
    localparam int unsigned CNT_W = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 abort;
    logic [WIDTH-1:0]     value;
    logic [NCH-1:0]       par_mask;
    logic [CNT_W-1:0]     base_dly;
    logic [CNT_W-1:0]     step_dly;
    logic [NCH*WIDTH-1:0] ch_data;
    logic [NCH-1:0]       ch_valid;
    logic                 busy;
    logic                 done;

    int tests_run    = 0;
    int tests_failed = 0;

    fork_load_sequencer #(
        .NCH   (NCH),
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .abort_i    (abort),
        .value_i    (value),
        .par_mask_i (par_mask),
        .base_dly_i (base_dly),
        .step_dly_i (step_dly),
        .ch_data_o  (ch_data),
        .ch_valid_o (ch_valid),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Drive a start; returns 1 unit after the acceptance edge (edge 0).
    task automatic start_run(input logic [1:0] v, input logic [5:0] p,
                             input logic [3:0] b, input logic [3:0] s);
        value    = v;
        par_mask = p;
        base_dly = b;
        step_dly = s;
        start    = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        value    = 2'b11;
        par_mask = 6'b111111;
        base_dly = 4'd0;
        step_dly = 4'd0;
        rst   = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        step();
        step();
        rst   = 1'b0;
        start = 1'b0;
        tests_run++;
        if (ch_data !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_data got %h want 000", ch_data);
        end
        tests_run++;
        if (ch_valid !== 6'b000000) begin
            tests_failed++;
            $display("FAIL reset_valid got %b want 000000", ch_valid);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_done got %b want 0", done);
        end
    endtask

    task automatic test_fork_stagger();
        logic [5:0] ev;
        do_reset();
        start_run(2'b10, 6'b100011, 4'd1, 4'd2);
        // Later input changes must not affect the run.
        value    = 2'b01;
        par_mask = 6'b000000;
        base_dly = 4'd0;
        step_dly = 4'd0;
        for (int n = 1; n <= 10; n++) begin
            step();
            ev = (n < 2) ? 6'b000000 : (n < 5) ? 6'b100111 : (n < 8) ? 6'b101111 : 6'b111111;
            tests_run++;
            if (ch_valid !== ev) begin
                tests_failed++;
                $display("FAIL stagger_valid edge %0d got %b want %b", n, ch_valid, ev);
            end
            tests_run++;
            if (busy !== (n <= 8)) begin
                tests_failed++;
                $display("FAIL stagger_busy edge %0d got %b want %b", n, busy, (n <= 8));
            end
            tests_run++;
            if (done !== (n == 9)) begin
                tests_failed++;
                $display("FAIL stagger_done edge %0d got %b want %b", n, done, (n == 9));
            end
        end
        tests_run++;
        if (ch_data !== 12'hAAA) begin
            tests_failed++;
            $display("FAIL stagger_data got %h want aaa", ch_data);
        end
    endtask

    task automatic test_all_parallel();
        do_reset();
        start_run(2'b11, 6'b111111, 4'd0, 4'd5);
        step();
        tests_run++;
        if (ch_valid !== 6'b111111 || ch_data !== 12'hFFF || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL par_edge1 got valid=%b data=%h busy=%b want 111111 fff 1",
                     ch_valid, ch_data, busy);
        end
        step();
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL par_join got done=%b busy=%b want 1 0", done, busy);
        end
        step();
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL par_done_width got %b want 0", done);
        end
    endtask

    task automatic test_all_sequential();
        logic [5:0] ev;
        do_reset();
        start_run(2'b01, 6'b000000, 4'd0, 4'd0);
        for (int n = 1; n <= 8; n++) begin
            step();
            ev = (n >= 6) ? 6'b111111 : 6'((7'd1 << n) - 7'd1);
            tests_run++;
            if (ch_valid !== ev || busy !== (n <= 6) || done !== (n == 7)) begin
                tests_failed++;
                $display("FAIL seq edge %0d got valid=%b busy=%b done=%b want %b %b %b",
                         n, ch_valid, busy, done, ev, (n <= 6), (n == 7));
            end
            if (n == 3) begin
                tests_run++;
                if (ch_data !== 12'h015) begin
                    tests_failed++;
                    $display("FAIL seq_data_edge3 got %h want 015", ch_data);
                end
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        start_run(2'b10, 6'b100011, 4'd1, 4'd2);
        step();
        // A start while busy must be ignored.
        value    = 2'b01;
        par_mask = 6'b000000;
        start    = 1'b1;
        step();
        start = 1'b0;
        tests_run++;
        if (ch_valid !== 6'b100111 || ch_data !== 12'h82A) begin
            tests_failed++;
            $display("FAIL abort_pre got valid=%b data=%h want 100111 82a", ch_valid, ch_data);
        end
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_stop got busy=%b done=%b want 0 0", busy, done);
        end
        tests_run++;
        if (ch_valid !== 6'b100111 || ch_data !== 12'h82A) begin
            tests_failed++;
            $display("FAIL abort_keep got valid=%b data=%h want 100111 82a", ch_valid, ch_data);
        end
        for (int n = 6; n <= 10; n++) begin
            step();
            tests_run++;
            if (done !== 1'b0 || ch_valid !== 6'b100111) begin
                tests_failed++;
                $display("FAIL abort_no_join edge %0d got done=%b valid=%b want 0 100111",
                         n, done, ch_valid);
            end
        end
        // Abort and start together while idle: abort wins.
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || ch_valid !== 6'b100111) begin
            tests_failed++;
            $display("FAIL abort_start_idle got busy=%b valid=%b want 0 100111", busy, ch_valid);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        start_run(2'b10, 6'b100011, 4'd1, 4'd2);
        for (int n = 1; n <= 6; n++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++;
        if (ch_data !== 12'h000 || ch_valid !== 6'b000000 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_reset got data=%h valid=%b busy=%b done=%b want 000 0 0 0",
                     ch_data, ch_valid, busy, done);
        end
        start_run(2'b01, 6'b111111, 4'd0, 4'd0);
        step();
        tests_run++;
        if (ch_valid !== 6'b111111 || ch_data !== 12'h555) begin
            tests_failed++;
            $display("FAIL post_reset_run got valid=%b data=%h want 111111 555", ch_valid, ch_data);
        end
        step();
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset_join got %b want 1", done);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        start_run(2'b10, 6'b100011, 4'd1, 4'd2);
        for (int n = 1; n <= 9; n++) step();
        tests_run++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_first_join got done=%b busy=%b want 1 0", done, busy);
        end
        // Start during the done cycle; this edge becomes the new edge 0.
        start_run(2'b01, 6'b100011, 4'd1, 4'd2);
        tests_run++;
        if (busy !== 1'b1 || ch_valid !== 6'b000000 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_accept got busy=%b valid=%b done=%b want 1 000000 0",
                     busy, ch_valid, done);
        end
        step();
        step();
        tests_run++;
        if (ch_valid !== 6'b100111 || ch_data !== 12'h695) begin
            tests_failed++;
            $display("FAIL b2b_par got valid=%b data=%h want 100111 695", ch_valid, ch_data);
        end
        for (int n = 3; n <= 9; n++) step();
        tests_run++;
        if (done !== 1'b1 || ch_valid !== 6'b111111 || ch_data !== 12'h555) begin
            tests_failed++;
            $display("FAIL b2b_join got done=%b valid=%b data=%h want 1 111111 555",
                     done, ch_valid, ch_data);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        value    = '0;
        par_mask = '0;
        base_dly = '0;
        step_dly = '0;
        test_reset();
        test_fork_stagger();
        test_all_parallel();
        test_all_sequential();
        test_abort();
        test_reset_midrun();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fork_load_sequencer.md
Name: fork_load_sequencer

Overview:
- Parametrised, clocked successor to the fixed fork/join staged-assignment block.
- On a start command, loads one captured value into NCH output channels.
- Channels selected by a parallel mask all load together after a programmable base delay.
- The remaining channels then load one at a time, in ascending index order, with a programmable gap between loads. A done pulse marks the join.
- Used as a stimulus/initialisation sequencer in the digital-logic design set.

Parameters:
- NCH, 6, number of output channels (2..16)
- WIDTH, 2, bits per channel
- CNT_W, 4, width of the base_dly and step_dly counters

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  request a new run; accepted only when busy=0
- abort  in  1  stop the current run
- value  in  WIDTH  value loaded into every channel
- par_mask  in  NCH  1 = channel loads in the parallel (fork) group
- base_dly  in  CNT_W  cycles before the parallel load
- step_dly  in  CNT_W  extra gap cycles between sequential loads
- ch_data  out  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- ch_valid  out  NCH  bit i set once channel i has loaded in the current run
- busy  out  1  run in progress
- done  out  1  one-cycle join pulse

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. No asynchronous reset anywhere.
- Reset values: ch_data=0, ch_valid=0, busy=0, done=0, FSM=IDLE. Reset mid-run aborts immediately; no further loads and no done pulse.
- States: IDLE, WAIT_BASE, LOAD_PAR, SEQ_GAP, SEQ_LOAD, FINISH.
- Start acceptance (start=1, busy=0, abort=0 at edge T):
  - capture value, par_mask, base_dly and step_dly into internal registers;
  - clear ch_valid;
  - set busy=1 from T+1.
  - ch_data is not cleared; unloaded channels retain their old data.
- Parallel load at edge T+1+base_dly (base_dly=0 gives T+1):
  - every channel with par_mask[i]=1 loads value and sets ch_valid[i];
  - the lowest-index channel with par_mask=0 (sequential index k=0) also loads at this edge.
- Sequential channel k loads at edge T+1+base_dly+k*(step_dly+1). step_dly=0 means back-to-back cycles.
- Next-channel selection: the lowest unloaded channel with par_mask=0 and an index above the last sequential channel loaded.
- Join: at the edge after the last load, done=1 for exactly one cycle and busy=0. The FSM returns to IDLE.
- par_mask all ones: the parallel load is the last load; done follows one cycle later.
- par_mask all zeros: the first load is channel 0 alone.
- Inputs are sampled only at acceptance; later changes have no effect on the run.
- start while busy=1 is ignored; there is no queueing.
- A start in the same cycle as done is accepted, because busy has already dropped.
- abort=1 while busy:
  - FSM returns to IDLE at the next edge, and busy=0 from then;
  - a load scheduled for that same edge is suppressed;
  - ch_valid and ch_data keep the loads already done; no done pulse.
- abort and start together while idle: abort wins and start is ignored.
- Counters do not wrap within a run. The base and gap counters saturate and then reload.

Decomposition:
- Shared package fork_seq_pkg holds:
  - the state enum (IDLE..FINISH);
  - function lowest_set(mask) returning the index and a found flag.
- One natural sub-module, seq_pick: combinational next-channel selection from the remaining sequential mask. A counter for base and gap delays is inlined in the top.

Test Plan:
- NCH=6, value=2'b10, par_mask=6'b100011, base_dly=1, step_dly=2, start at cycle 0 -> ch0, ch1, ch5 and ch2 load at edge 2; ch3 at edge 5; ch4 at edge 8; done pulse at edge 9; busy high for edges 1..8.
- par_mask=6'b111111, base_dly=0 -> all channels load at edge 1; done at edge 2; ch_valid=6'b111111.
- par_mask=0, base_dly=0, step_dly=0 -> ch0..ch5 load on edges 1..6, one per cycle; done at edge 7.
- Run as in the first scenario with abort at cycle 4 -> ch_valid=6'b100111 (ch0, ch1, ch2, ch5 loaded), ch3/ch4 data unchanged, no done, busy=0 from edge 5; a second start at cycle 2 is ignored.
- rst asserted at cycle 6 of the first scenario -> all outputs 0 at edge 7; a new start at cycle 8 runs normally.
- start with a new value=2'b01 on the same cycle as done -> accepted, ch_valid cleared next edge, new loads follow the standard timing.
